// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses a single 4-bit ripple-carry slice, one nibble per cycle,
// least-significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N   = WIDTH / 4;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 4-bit ripple slice; also returns the carry into bit 3 for signed overflow.
  // Result layout: {carry_into_bit3, carry_out, sum[3:0]}.
  function automatic logic [5:0] add4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] c_v;
    logic [3:0] s_v;
    c_v[0] = c;
    for (int i = 0; i < 4; i++) begin
      s_v[i]     = x[i] ^ y[i] ^ c_v[i];
      c_v[i + 1] = (x[i] & y[i]) | (c_v[i] & (x[i] ^ y[i]));
    end
    return {c_v[3], c_v[4], s_v};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [K_W-1:0]   k_r;

  logic [5:0]       slice_s;
  logic             last_s;

  assign slice_s = add4(a_r[{k_r, 2'b00} +: 4], b_r[{k_r, 2'b00} +: 4], carry_r);
  assign last_s  = (k_r == K_W'(N - 1));

  // State register; handshake flags are registered from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= in_ready_s;
      out_valid <= out_valid_s;
      busy      <= busy_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the flags leave flops directly.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_s)
      IDLE:    in_ready_s = 1'b1;
      RUN:     busy_s     = 1'b1;
      DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: in_ready_s = 1'b1;
    endcase
  end

  // Operand capture, nibble sequencing and result load on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      k_r     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            k_r     <= '0;
          end
        end
        RUN: begin
          acc_r[{k_r, 2'b00} +: 4] <= slice_s[3:0];
          carry_r                  <= slice_s[4];
          k_r                      <= k_r + K_W'(1);
          if (last_s) begin
            sum  <= {slice_s[3:0], acc_r[WIDTH-5:0]};
            cout <= slice_s[4];
            ovf  <= slice_s[5] ^ slice_s[4];
          end
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed, table-driven bench for nibble_serial_adder at WIDTH = 16.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[9];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full transaction: accept, check latency and result, then hand it off.
  task automatic do_op(input vec_t v);
    int lat;
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = ~cin;
    chk("busy_run", {31'd0, busy}, 32'd1);
    chk("in_ready_run", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 32'd4);
    chk("sum", {16'd0, sum}, {16'd0, v.s});
    chk("cout", {31'd0, cout}, {31'd0, v.co});
    chk("ovf", {31'd0, ovf}, {31'd0, v.ov});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulse_cyc[2];
    logic [W-1:0] pulse_sum[2];
    int npulse;
    int run_len;
    int max_run;
    bit first_acc_done;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // Backpressure: DONE must hold steady while inputs churn.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_latency", lat, 32'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom);
      step();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_result", {15'd0, cout, ovf, sum}, {15'd0, 2'b00, 16'h5555});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
    do_op(vecs[3]);

    // Reset during the second RUN cycle of AAAA + 5555.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    do_op('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});

    // Back-to-back with both handshakes tied high.
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    npulse = 0; run_len = 0; max_run = 0; first_acc_done = 1'b0;
    pulse_cyc[0] = 0; pulse_cyc[1] = 0; pulse_sum[0] = '0; pulse_sum[1] = '0;
    for (int c = 1; c <= 16; c++) begin
      if (in_ready && !first_acc_done) begin
        first_acc_done = 1'b1;
        step();
        a = 16'h00FF; b = 16'h0001;
      end else begin
        step();
      end
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (npulse < 2) begin
          pulse_cyc[npulse] = c;
          pulse_sum[npulse] = sum;
        end
        npulse++;
      end else begin
        run_len = 0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_pulses", (npulse >= 2) ? 32'd1 : 32'd0, 32'd1);
    chk("b2b_sum0", {16'd0, pulse_sum[0]}, 32'h0003);
    chk("b2b_sum1", {16'd0, pulse_sum[1]}, 32'h0100);
    chk("b2b_gap", pulse_cyc[1] - pulse_cyc[0], 32'd6);
    chk("b2b_width", max_run, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around one 4-bit ripple-carry slice (a[3:0] + b[3:0] + cin producing sum[3:0] and cout).
- Sequences operands one nibble per cycle, least-significant nibble first, through that slice.
- Registers the carry between nibbles and presents the full result with valid/ready handshakes on both sides.
- Serves datapath stages that need wide additions but only have area budget for one 4-bit adder.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 8. N = WIDTH/4 is the nibble count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values, applied immediately on rst assertion regardless of clk:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - sum = 0; cout = 0; ovf = 0.
  - Internal operand registers, carry register and nibble counter = 0.
- State IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: capture a, b, cin into internal registers, clear nibble counter k to 0, go to RUN.
- State RUN:
  - in_ready = 0; in_valid is ignored.
  - Each edge adds nibble k of A, nibble k of B and the carry register through the 4-bit slice.
  - Result nibble is written into the internal accumulator at bits [4k+3:4k]; carry register takes the slice carry out; k increments.
  - On the edge that processes nibble N-1:
    - Load sum from the accumulator including the final nibble.
    - cout = slice carry out.
    - ovf = carry into bit 3 of the slice XOR slice carry out.
    - Go to DONE.
- State DONE:
  - out_valid = 1.
  - sum, cout and ovf are stable until the handshake.
  - On an edge with out_ready = 1: go to IDLE.
- Latency and throughput:
  - Accept edge is cycle 0; out_valid rises after edge N (N = 4 for WIDTH = 16).
  - in_ready returns to 1 the cycle after the output handshake.
  - Peak throughput is one operation per N+2 cycles.
- Output hold rules:
  - sum, cout and ovf update only on the DONE-entry edge.
  - They hold their last result through IDLE and RUN; they are meaningful only when out_valid = 1.
- out_ready:
  - No effect outside DONE.
  - Holding out_ready = 1 continuously is legal and gives one idle cycle between results.
- Simultaneous events:
  - In DONE, in_valid = 1 with out_ready = 1 does not accept new operands, because in_ready = 0.
  - The new operation is accepted in the following IDLE cycle.
- Reset mid-operation:
  - The in-flight operation is discarded, all outputs go to their reset values, and no out_valid pulse is produced.
- Carry chain:
  - Carry propagates across all N nibbles.
  - Result is identical to a single-cycle WIDTH-bit add, taken modulo 2^WIDTH with carry in cout.
- Operand capture:
  - Inputs a, b and cin may change freely after the accept edge; internal registers hold the captured values.

Test Plan:
- Basic add, WIDTH = 16: a = 0x1234, b = 0x4321, cin = 0 -> out_valid rises 4 cycles after accept; sum = 0x5555, cout = 0, ovf = 0.
- Full carry ripple: a = 0xFFFF, b = 0x0000, cin = 1 -> sum = 0x0000, cout = 1, ovf = 0. Also a = 0x0FFF, b = 0x0001, cin = 0 -> sum = 0x1000, cout = 0, which checks carry crossing every nibble boundary.
- Signed overflow: a = 0x7FFF, b = 0x0001 -> sum = 0x8000, cout = 0, ovf = 1. Also a = 0x8000, b = 0x8000 -> sum = 0x0000, cout = 1, ovf = 1.
- Backpressure: hold out_ready = 0 for 6 cycles in DONE while toggling in_valid and changing a/b -> out_valid = 1, in_ready = 0, and sum/cout/ovf unchanged throughout. Raising out_ready then gives IDLE on the next edge, followed by a normal new accept.
- Reset mid-op: assert rst during the second RUN cycle of 0xAAAA + 0x5555 -> immediately out_valid = 0, busy = 0, sum = 0. After rst is released, 0x0001 + 0x0001 yields sum = 0x0002 with no stale out_valid.
- Back-to-back with out_ready tied high and in_valid tied high, operands 0x0001+0x0002 then 0x00FF+0x0001 -> results 0x0003 then 0x0100. out_valid pulses are N+2 = 6 cycles apart, each 1 cycle wide.
